demux3_buf: RTL
===============

# demux3_buf

Registered 1-to-3 demultiplexer with valid/ready handshakes. It routes a 32-bit word from a single producer to one of three consumers. The 3-bit selector is encoded exactly as on the datapath's 3-input muxes: 000, 001 and 010 select channels 0, 1 and 2, and every other code falls back to channel 0. It sits between a shared result source and the datapath's destination registers. Each channel has a one-entry buffer, so a stalled consumer only blocks traffic addressed to it.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data_in and every data_out_N
- SEL_WIDTH, 3, width of selector

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer presents a word
- in_ready  out  1  the target channel can accept this cycle (combinational)
- selector  in  SEL_WIDTH  destination code, sampled with data_in
- data_in  in  DATA_WIDTH  word to route
- out_valid_0 / out_valid_1 / out_valid_2  out  1  channel N buffer holds a word
- out_ready_0 / out_ready_1 / out_ready_2  in  1  consumer N accepts this cycle
- data_out_0 / data_out_1 / data_out_2  out  DATA_WIDTH  channel N buffered word
- sel_err  out  1  one-cycle pulse: an out-of-range selector was accepted

## Operation
- Decode: 000 -> ch0; 001 -> ch1; 010 -> ch2; 011..111 -> ch0, with sel_err set.
- in_ready = (target buffer empty) OR (target out_valid AND its out_ready). The target is the decoded selector of the current cycle.
- in_ready depends only on selector and the target channel's state and out_ready. It never depends on in_valid.
- Accept = in_valid AND in_ready. On accept, the target buffer loads data_in and its out_valid is 1 next cycle.
- Drain = out_valid_N AND out_ready_N. On drain without a same-cycle accept to that channel, out_valid_N goes to 0 next cycle.
- Drain and accept on the same channel in the same cycle: the buffer loads the new word and out_valid stays 1. There is no bubble.
- Non-target channels are unaffected by an accept and drain independently.
- data_out_N holds its value whenever out_valid_N=1 and out_ready_N=0. No word is ever overwritten or dropped.
- After a drain, data_out_N keeps its last value. Consumers must qualify it with out_valid.
- sel_err is registered. It is 1 for exactly the cycle after an accept with an out-of-range selector, and 0 otherwise. A rejected out-of-range request never sets sel_err.
- Per-channel state is 2 states: EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on hold, or on drain with accept.

## Timing
- Reset values: out_valid_0..2 = 0, data_out_0..2 = 0, sel_err = 0. in_ready is therefore 1 for any selector in the first cycle after reset.
- Reset asserted mid-operation: all buffered words are discarded on that edge. No accept or drain takes effect in a reset cycle.
- Latency: accept at edge k puts the word on data_out_N, with out_valid_N=1, after edge k.
- Throughput: one word per cycle into any single channel whose consumer holds ready=1. Alternating channels also sustains one word per cycle.
- in_valid high with in_ready low: the producer must hold data_in and selector stable until accept. The block does not latch anything early.
- Combinational paths: selector and out_ready_N -> in_ready only. No path from in_valid to any output.

## Structure
- Shared package holds:
  - the selector codes SEL_CH0=3'b000, SEL_CH1=3'b001, SEL_CH2=3'b010;
  - the channel-count constant NUM_CH=3;
  - a 1-bit slot-state enum {EMPTY, FULL}.
- One natural sub-module, demux_slot. It is a single one-entry buffer with load/drain logic and outputs valid, data and can_accept. It is instantiated three times.
- The top level holds the decoder, the in_ready mux and the sel_err register.

## Test plan
- Reset, then in_valid=1, selector=001, data_in=32'hDEAD_BEEF, out_ready_1=1 for one cycle. Expected: out_valid_1=1 with data_out_1=32'hDEAD_BEEF one cycle later. out_valid_0 and out_valid_2 stay 0, and sel_err stays 0.
- selector=111, data_in=32'h0000_0042. Expected: accepted into ch0, data_out_0=32'h42, and sel_err=1 for exactly one cycle.
- out_ready_2=0, with two consecutive writes to 010 (32'h1 then 32'h2). Expected:
  - the first write is accepted; in_ready=0 for the second;
  - data_out_2 holds 32'h1;
  - when out_ready_2 rises, 32'h1 drains and 32'h2 is accepted in the same cycle, and out_valid_2 never drops.
- While ch2 is blocked as above, a write with selector=000 and 32'hA5. Expected: in_ready=1, and ch0 receives 32'hA5 with no effect on ch2.
- Streaming to ch0 with out_ready_0=1 for 8 cycles, values 0..7. Expected: 8 accepts in 8 cycles and out_valid_0 continuously 1 from cycle 1.
- ch1 and ch2 both FULL, reset asserted for one cycle. Expected: all out_valid=0, all data_out=0 and sel_err=0 next cycle, with in_ready=1.

Source files
------------

// File: rtl/demux3_buf_pkg.sv
// demux3_buf_pkg: selector codes, channel count and slot state shared by the demux
package demux3_buf_pkg;
   localparam logic [2:0] SEL_CH0 = 3'b000;
   localparam logic [2:0] SEL_CH1 = 3'b001;
   localparam logic [2:0] SEL_CH2 = 3'b010;
   localparam int NUM_CH = 3;
   typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry valid/ready buffer that can drain and reload in the same cycle
module demux_slot
   import demux3_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  ready,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  can_accept
);
   slot_state_t state, state_n;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         data  <= '0;
      end else begin
         state <= state_n;
         if (load) data <= din;
      end
   end
   always_comb begin
      state_n    = load ? FULL : (state == FULL && ready) ? EMPTY : state;
      valid      = state == FULL;
      can_accept = state == EMPTY || ready;
   end
endmodule

// File: rtl/demux3_buf.sv
// demux3_buf: registered 1-to-3 valid/ready demultiplexer with a one-entry buffer per channel
module demux3_buf
   import demux3_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_WIDTH-1:0]  selector,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  out_valid_0,
   output logic                  out_valid_1,
   output logic                  out_valid_2,
   input  logic                  out_ready_0,
   input  logic                  out_ready_1,
   input  logic                  out_ready_2,
   output logic [DATA_WIDTH-1:0] data_out_0,
   output logic [DATA_WIDTH-1:0] data_out_1,
   output logic [DATA_WIDTH-1:0] data_out_2,
   output logic                  sel_err
);
   logic [NUM_CH-1:0] tgt, ld, vld, can, rdy;
   logic [DATA_WIDTH-1:0] dout [NUM_CH];
   logic bad, acc;
   assign rdy    = {out_ready_2, out_ready_1, out_ready_0};
   assign tgt[1] = selector == SEL_WIDTH'(SEL_CH1);
   assign tgt[2] = selector == SEL_WIDTH'(SEL_CH2);
   // every unrecognised code falls back to channel 0
   assign tgt[0] = ~(tgt[1] | tgt[2]);
   assign bad    = tgt[0] && selector != SEL_WIDTH'(SEL_CH0);
   assign in_ready = |(tgt & can);
   assign acc    = in_valid && in_ready;
   assign ld     = acc ? tgt : '0;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk        (clk),
         .reset      (reset),
         .load       (ld[i]),
         .ready      (rdy[i]),
         .din        (data_in),
         .valid      (vld[i]),
         .data       (dout[i]),
         .can_accept (can[i])
      );
   end
   assign {out_valid_2, out_valid_1, out_valid_0} = vld;
   assign data_out_0 = dout[0];
   assign data_out_1 = dout[1];
   assign data_out_2 = dout[2];
   always_ff @(posedge clk) begin
      if (reset) sel_err <= 1'b0;
      else sel_err <= acc && bad;
   end
endmodule
